iir_decim_out: RTL

Downstream output stage for the `iir` filter. It takes the filter's 16-bit signed `y(n)` stream and decimates it by 2^LOG2_N with accumulate-and-dump averaging. Each average is saturated to an 8-bit signed sample and buffered in a small FIFO, which is drained over a valid/ready handshake. It sits between `iir.data_out` and any slower consumer, such as a DAC or UART framer.

---
 rtl/iir_decim_pkg.sv | 27 ++
 rtl/iir_decim_fifo.sv | 60 ++++++
 rtl/iir_decim_out.sv | 113 +++++++++++
 3 files changed

// File: rtl/iir_decim_pkg.sv
// Shared constants and the signed saturate helper for the iir decimating output stage.
package iir_decim_pkg;

  localparam int DEF_IN_W       = 16;
  localparam int DEF_OUT_W      = 8;
  localparam int DEF_LOG2_N     = 2;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam int OUT_MAX = 127;
  localparam int OUT_MIN = -128;

  // Clamp v into the range of a w-bit two's complement number.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/iir_decim_fifo.sv
// Small synchronous FIFO; head is shown combinationally and reads 0 while empty.
module iir_decim_fifo
  import iir_decim_pkg::*;
#(
  parameter int WIDTH = DEF_OUT_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_wr;
  logic              w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (ADDR_W + 1)'(DEPTH));
  assign w_rd    = i_pop && !o_empty;
  // A pop on the same edge frees the slot a full push needs.
  assign w_wr    = i_push && (!o_full || w_rd);
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/iir_decim_out.sv
// Accumulate-and-dump decimator with saturation and output FIFO for the iir filter.
// Define IIR_DECIM_ROUND_EN for round-half-up averaging; otherwise results truncate toward -inf.
module iir_decim_out
  import iir_decim_pkg::*;
#(
  parameter int IN_W       = DEF_IN_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int LOG2_N     = DEF_LOG2_N,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] data_out,
  output logic                    sat_flag,
  output logic [7:0]              drop_cnt
);

`ifdef IIR_DECIM_ROUND_EN
  localparam int GUARD = 1;
`else
  localparam int GUARD = 0;
`endif

  localparam int ACC_W = IN_W + LOG2_N + GUARD;
  localparam logic [LOG2_N-1:0] PH_LAST = '1;

  logic signed [ACC_W-1:0] r_acc;
  logic [LOG2_N-1:0]       r_ph;
  logic                    r_sat_flag;
  logic [7:0]              r_drop_cnt;

  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_q;
  logic signed [31:0]      w_q_ext;
  logic signed [31:0]      w_sat;
  logic [OUT_W-1:0]        w_res;
  logic                    w_clip;
  logic                    w_dump;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_drop;
  logic [OUT_W-1:0]        w_head;

  assign w_dump = (r_ph == PH_LAST);
  assign w_sum  = r_acc + ACC_W'(data_in);

`ifdef IIR_DECIM_ROUND_EN
  localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(2 ** (LOG2_N - 1));
  assign w_q = (w_sum + ROUND_HALF) >>> LOG2_N;
`else
  assign w_q = w_sum >>> LOG2_N;
`endif

  assign w_q_ext = 32'(w_q);
  assign w_sat   = sat_signed(w_q_ext, OUT_W);
  assign w_clip  = (w_sat != w_q_ext);
  assign w_res   = OUT_W'(w_sat);

  assign w_push = in_valid && w_dump;
  assign w_pop  = !w_empty && out_ready;
  assign w_drop = w_push && w_full && !w_pop;

  iir_decim_fifo #(
    .WIDTH(OUT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_data (w_res),
    .i_pop  (w_pop),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_head (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_ph       <= '0;
      r_sat_flag <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (in_valid) begin
        if (w_dump) begin
          r_acc <= '0;
          r_ph  <= '0;
        end else begin
          r_acc <= w_sum;
          r_ph  <= r_ph + LOG2_N'(1);
        end
      end
      if (w_push && w_clip) begin
        r_sat_flag <= 1'b1;
      end
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign out_valid = !w_empty;
  assign data_out  = w_head;
  assign sat_flag  = r_sat_flag;
  assign drop_cnt  = r_drop_cnt;

endmodule
